// File: rtl/vga_note_sched_if.sv
// ----------------------------------------------------------------------------
// vga_note_sched_if
// Bundles the signals exchanged between the note scheduler and its
// neighbours: the line coordinate from the VGA timing generator, the two
// requester valid/ready/note channels, and the display-side outputs.
//
//   pos_y       10  line coordinate from vga_ctrl
//   a_valid      1  requester A (keyboard) offers a_note
//   a_note       8  requester A note pattern
//   a_ready      1  requester A offer accepted this cycle
//   b_valid      1  requester B (auto-play) offers b_note
//   b_note       8  requester B note pattern
//   b_ready      1  requester B offer accepted this cycle
//   note_disp    8  pattern driving the vga_pic note input
//   frame_tick   1  one-cycle frame-boundary pulse
//   pend_valid   1  a pattern is latched and awaiting commit
//
// master: the environment (timing generator and requesters).
// slave : the scheduler itself.
// ----------------------------------------------------------------------------
interface vga_note_sched_if;
   logic [9:0] pos_y;
   logic       a_valid;
   logic [7:0] a_note;
   logic       a_ready;
   logic       b_valid;
   logic [7:0] b_note;
   logic       b_ready;
   logic [7:0] note_disp;
   logic       frame_tick;
   logic       pend_valid;

   modport master (
      output pos_y, a_valid, a_note, b_valid, b_note,
      input  a_ready, b_ready, note_disp, frame_tick, pend_valid
   );

   modport slave (
      input  pos_y, a_valid, a_note, b_valid, b_note,
      output a_ready, b_ready, note_disp, frame_tick, pend_valid
   );
endinterface

// File: rtl/vga_note_sched.sv
// ----------------------------------------------------------------------------
// vga_note_sched
// Arbitrates note patterns from two requesters (A = keyboard, B = auto-play)
// and commits the accepted pattern to the display only at the frame
// boundary, so the picture generator never sees a change mid-frame.
//
// Ports:
//   vga_clk    pixel clock, the only clock of this block
//   sys_rst_n  asynchronous active-low reset
//   bus        vga_note_sched_if.slave (pos_y, A/B valid/ready/note,
//              note_disp, frame_tick, pend_valid)
//
// Parameters:
//   V_ACTIVE     first line outside the active area (frame boundary line)
//   HOLD_FRAMES  frames a committed pattern stays visible (1..15), only
//                meaningful when the hold counter is compiled in
//
// Build option:
//   VGA_NOTE_SCHED_HOLD_EN  when defined, a 4-bit hold counter clears the
//                           display HOLD_FRAMES frame ticks after a commit
//                           if nothing new was committed meanwhile. When
//                           undefined, the last committed pattern stays.
// ----------------------------------------------------------------------------
module vga_note_sched #(
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned HOLD_FRAMES = 4
) (
   input logic             vga_clk,
   input logic             sys_rst_n,
   vga_note_sched_if.slave bus
);

   localparam logic [9:0] V_EDGE = 10'(V_ACTIVE);

   if (HOLD_FRAMES < 1 || HOLD_FRAMES > 15) begin : g_hold_range_check
      $error("vga_note_sched: HOLD_FRAMES must be in 1..15");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [9:0] prev_y_q;
   logic       tick_q, tick_d;
   logic [7:0] pend_q, pend_d;
   logic [7:0] disp_q, disp_d;
   // 1 = B has priority at the next tie (A was granted at the last transfer)
   logic       rr_b_q, rr_b_d;

   logic       grant_a, grant_b;
   logic       ready_a, ready_b;
   logic       xfer_a, xfer_b;

`ifdef VGA_NOTE_SCHED_HOLD_EN
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_FRAMES);
   logic [3:0] hold_q, hold_d;
`endif

   // A lone requester always wins; a tie goes to whoever lost last time.
   assign grant_a = bus.a_valid && (!bus.b_valid || !rr_b_q);
   assign grant_b = bus.b_valid && (!bus.a_valid || rr_b_q);

   // No acceptance in the tick cycle: the commit and a new latch would
   // otherwise compete for pend_q in the same cycle.
   assign ready_a = (state_q == IDLE) && !tick_q && grant_a;
   assign ready_b = (state_q == IDLE) && !tick_q && grant_b;

   assign xfer_a  = ready_a && bus.a_valid;
   assign xfer_b  = ready_b && bus.b_valid;

   // Tick on the first cycle pos_y shows V_ACTIVE, registered one cycle.
   assign tick_d  = (bus.pos_y == V_EDGE) && (prev_y_q != V_EDGE);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      disp_d  = disp_q;
      rr_b_d  = rr_b_q;
`ifdef VGA_NOTE_SCHED_HOLD_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (xfer_a || xfer_b) begin
               state_d = ARMED;
               pend_d  = xfer_a ? bus.a_note : bus.b_note;
               rr_b_d  = xfer_a;
            end
         end
         ARMED: begin
            if (tick_q) begin
               state_d = IDLE;
               disp_d  = pend_q;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef VGA_NOTE_SCHED_HOLD_EN
      if (tick_q) begin
         if (state_q == ARMED) begin
            hold_d = HOLD_LOAD;
         end else if (hold_q != 4'd0) begin
            hold_d = hold_q - 4'd1;
            // Last held frame has elapsed without a fresh commit.
            if (hold_q == 4'd1) begin
               disp_d = 8'h00;
            end
         end
      end
`endif
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= IDLE;
         // Starting at V_ACTIVE suppresses a tick if reset releases on
         // the boundary line.
         prev_y_q <= V_EDGE;
         tick_q   <= 1'b0;
         pend_q   <= 8'h00;
         disp_q   <= 8'h00;
         rr_b_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_y_q <= bus.pos_y;
         tick_q   <= tick_d;
         pend_q   <= pend_d;
         disp_q   <= disp_d;
         rr_b_q   <= rr_b_d;
      end
   end

`ifdef VGA_NOTE_SCHED_HOLD_EN
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold_q <= 4'd0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

   assign bus.a_ready    = ready_a;
   assign bus.b_ready    = ready_b;
   assign bus.note_disp  = disp_q;
   assign bus.frame_tick = tick_q;
   assign bus.pend_valid = (state_q == ARMED);

endmodule

// File: tb/tb_vga_note_sched.sv
`timescale 1ns/1ps
module tb_vga_note_sched;
   localparam int VA       = 20;
   localparam int V_TOTAL  = 25;
   localparam int LINE_CYC = 2;
   localparam int HOLD     = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   vga_note_sched_if bus();

   vga_note_sched #(.V_ACTIVE(VA), .HOLD_FRAMES(HOLD)) dut (
      .vga_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- pos_y generator: LINE_CYC cycles per line ----------
   int line_cnt = 0;
   initial begin
      bus.pos_y = 10'd0;
      forever begin
         @(posedge clk); #1;
         if (line_cnt == LINE_CYC - 1) begin
            line_cnt  = 0;
            bus.pos_y = (int'(bus.pos_y) == V_TOTAL - 1) ? 10'd0 : bus.pos_y + 10'd1;
         end else begin
            line_cnt++;
         end
      end
   end

   // ---------------- requester drivers ----------------------------------
   // mode 0: one-shot offers only, 1: random offers, 2: continuous fixed note
   int         a_mode = 0, b_mode = 0;
   logic [7:0] a_fix = 8'h00, b_fix = 8'h00;
   bit         a_shot = 0, b_shot = 0;
   bit         a_acc = 0, b_acc = 0;

   initial begin
      bus.a_valid = 1'b0; bus.a_note = 8'h00;
      bus.b_valid = 1'b0; bus.b_note = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (a_acc) bus.a_valid = 1'b0;
         if (!bus.a_valid) begin
            if (a_mode == 2 || a_shot) begin
               bus.a_valid = 1'b1; bus.a_note = a_fix; a_shot = 0;
            end else if (a_mode == 1 && $urandom_range(0, 11) == 0) begin
               bus.a_valid = 1'b1; bus.a_note = 8'($urandom);
            end
         end
         if (b_acc) bus.b_valid = 1'b0;
         if (!bus.b_valid) begin
            if (b_mode == 2 || b_shot) begin
               bus.b_valid = 1'b1; bus.b_note = b_fix; b_shot = 0;
            end else if (b_mode == 1 && $urandom_range(0, 11) == 0) begin
               bus.b_valid = 1'b1; bus.b_note = 8'($urandom);
            end
         end
      end
   end

   // ---------------- behavioural model + per-cycle compare --------------
   // Model state describes the DUT outputs for the current cycle; after the
   // compare it is advanced with this cycle's inputs to the next cycle.
   logic [9:0] m_prev_y = 10'(VA);
   bit         m_tick   = 0;
   bit         m_has    = 0;     // a pattern is waiting for the boundary
   logic [7:0] m_pend   = 8'h00;
   logic [7:0] m_disp   = 8'h00;
   bit         m_b_turn = 0;     // B wins the next tie
   int         m_left   = 0;     // frame ticks the display may still stay
   logic [7:0] acc_log[$];       // notes accepted by the DUT, in order
   logic [7:0] disp_log[$];      // successive distinct note_disp values
   logic [7:0] last_disp = 8'h00;

   always @(negedge clk) begin
      bit exp_ra, exp_rb;
      a_acc = bus.a_valid && bus.a_ready && rst_n;
      b_acc = bus.b_valid && bus.b_ready && rst_n;
      if (a_acc) acc_log.push_back(bus.a_note);
      if (b_acc) acc_log.push_back(bus.b_note);
      if (bus.note_disp !== last_disp) begin
         disp_log.push_back(bus.note_disp);
         last_disp = bus.note_disp;
      end
      if (!rst_n) begin
         m_prev_y = 10'(VA); m_tick = 0; m_has = 0; m_pend = 8'h00;
         m_disp = 8'h00; m_b_turn = 0; m_left = 0;
         check("rst_note_disp", int'(bus.note_disp), 0);
         check("rst_frame_tick", int'(bus.frame_tick), 0);
         check("rst_pend_valid", int'(bus.pend_valid), 0);
      end else begin
         exp_ra = !m_has && !m_tick && bus.a_valid && (!bus.b_valid || !m_b_turn);
         exp_rb = !m_has && !m_tick && bus.b_valid && (!bus.a_valid || m_b_turn);
         check("note_disp", int'(bus.note_disp), int'(m_disp));
         check("frame_tick", int'(bus.frame_tick), int'(m_tick));
         check("pend_valid", int'(bus.pend_valid), int'(m_has));
         check("a_ready", int'(bus.a_ready), int'(exp_ra));
         check("b_ready", int'(bus.b_ready), int'(exp_rb));
         if (m_tick) begin
            if (m_has) begin
               m_disp = m_pend; m_has = 0; m_left = HOLD;
            end
`ifdef VGA_NOTE_SCHED_HOLD_EN
            else if (m_left > 0) begin
               m_left--;
               if (m_left == 0) m_disp = 8'h00;
            end
`endif
         end else if (exp_ra) begin
            m_has = 1; m_pend = bus.a_note; m_b_turn = 1;
         end else if (exp_rb) begin
            m_has = 1; m_pend = bus.b_note; m_b_turn = 0;
         end
         m_tick   = (int'(bus.pos_y) == VA) && (int'(m_prev_y) != VA);
         m_prev_y = bus.pos_y;
      end
   end

   // ---------------- helpers --------------------------------------------
   // Returns at the negedge of the next cycle in which frame_tick is high.
   task automatic wait_tick(input string name);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (bus.frame_tick) found = 1;
      end
      if (!found) check({name, "_tick_timeout"}, 0, 1);
   endtask

   task automatic drain(input string name);
      bit done = 0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         if (!bus.a_valid && !bus.b_valid && !bus.pend_valid) done = 1;
      end
      if (!done) check({name, "_drain_timeout"}, 0, 1);
   endtask

   task automatic wait_pend(input string name);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.pend_valid) seen = 1;
      end
      if (!seen) check({name, "_pend_timeout"}, 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios then random traffic --------------
   initial begin
      logic [7:0] exp_seq [4];
      logic [9:0] py_last;
      bit         found;
      exp_seq[0] = 8'h01; exp_seq[1] = 8'h80; exp_seq[2] = 8'h01; exp_seq[3] = 8'h80;

      // Both requesters continuously valid from reset: A, B, A, B.
      a_mode = 2; a_fix = 8'h01; b_mode = 2; b_fix = 8'h80;
      #1 rst_n = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) wait_tick("alt");
      @(negedge clk);
      check("alt_acc_count_ge4", int'(acc_log.size() >= 4), 1);
      check("alt_disp_count_ge4", int'(disp_log.size() >= 4), 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("alt_acc%0d", i), (i < acc_log.size()) ? int'(acc_log[i]) : -1, int'(exp_seq[i]));
         check($sformatf("alt_disp%0d", i), (i < disp_log.size()) ? int'(disp_log[i]) : -1, int'(exp_seq[i]));
      end
      a_mode = 0; b_mode = 0;
      drain("alt");

      // Single offer of 05 from A mid-frame.
      wait_tick("a05_sync");
      repeat (5) @(negedge clk);
      a_fix = 8'h05; a_shot = 1;
      @(negedge clk);
      check("a05_ready_hi", int'(bus.a_ready), 1);
      check("a05_pend_lo", int'(bus.pend_valid), 0);
      @(negedge clk);
      check("a05_pend_hi", int'(bus.pend_valid), 1);
      check("a05_ready_lo", int'(bus.a_ready), 0);
      wait_tick("a05");
      check("a05_pend_at_tick", int'(bus.pend_valid), 1);
      @(negedge clk);
      check("a05_disp", int'(bus.note_disp), 8'h05);
      check("a05_pend_cleared", int'(bus.pend_valid), 0);

      // B raises valid in the frame_tick cycle while IDLE.
      py_last = bus.pos_y;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (int'(bus.pos_y) == VA && int'(py_last) != VA) found = 1;
         else py_last = bus.pos_y;
      end
      check("btick_find_edge", int'(found), 1);
      b_fix = 8'hA7; b_shot = 1;
      @(negedge clk);
      check("btick_tick_hi", int'(bus.frame_tick), 1);
      check("btick_valid_hi", int'(bus.b_valid), 1);
      check("btick_ready_lo", int'(bus.b_ready), 0);
      @(negedge clk);
      check("btick_ready_next", int'(bus.b_ready), 1);
      @(negedge clk);
      check("btick_pend_hi", int'(bus.pend_valid), 1);
      wait_tick("btick");
      @(negedge clk);
      check("btick_disp", int'(bus.note_disp), 8'hA7);

      // Reset while ARMED with 3C pending discards it.
      a_fix = 8'h3C; a_shot = 1;
      wait_pend("rst3c");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst3c_disp_now", int'(bus.note_disp), 0);
      check("rst3c_pend_now", int'(bus.pend_valid), 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      wait_tick("rst3c");
      check("rst3c_tick_on_va", int'(bus.pos_y), VA);
      check("rst3c_pend_after", int'(bus.pend_valid), 0);
      @(negedge clk);
      check("rst3c_no_commit", int'(bus.note_disp), 0);

      // Commit FF then stay quiet: hold behaviour.
      a_fix = 8'hFF; a_shot = 1;
      wait_pend("hold");
      wait_tick("hold_commit");
      @(negedge clk);
      check("hold_disp_ff", int'(bus.note_disp), 8'hFF);
`ifdef VGA_NOTE_SCHED_HOLD_EN
      for (int k = 0; k < 3; k++) wait_tick("hold_a");
      @(negedge clk);
      check("hold_ff_after3", int'(bus.note_disp), 8'hFF);
      wait_tick("hold_b");
      @(negedge clk);
      check("hold_clear_after4", int'(bus.note_disp), 8'h00);
`else
      for (int k = 0; k < 10; k++) wait_tick("hold_a");
      @(negedge clk);
      check("hold_ff_after10", int'(bus.note_disp), 8'hFF);
`endif

      // Random traffic with occasional asynchronous resets.
      a_mode = 1; b_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 799) == 0) begin
            #2 rst_n = 1'b0;
            repeat (2) @(negedge clk);
            @(posedge clk); #1 rst_n = 1'b1;
         end
      end
      a_mode = 0; b_mode = 0;
      drain("rand");
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
